// File: rtl/interboard_msg_receiver.sv
`default_nettype none
//==============================================================================
// Module   : interboard_msg_receiver
// Brief    : Receive side of the board-to-board move protocol. Buffers incoming
//            message words, validates them, and replays them as memory
//            commands and GameControl events.
// Revision : 1.0 - initial release
//==============================================================================
module interboard_msg_receiver #(
    parameter int FIFO_DEPTH = 4,
    parameter int MAX_CARDS  = 106
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       interboard_rst,
    input  logic       interboard_en,
    input  logic [3:0] interboard_msg_type,
    input  logic [4:0] interboard_block_x,
    input  logic [2:0] interboard_block_y,
    input  logic [5:0] interboard_card,
    input  logic [2:0] interboard_sel_len,
    input  logic       interboard_move_dir,
    input  logic       mem_busy,
    output logic       mem_en,
    output logic [3:0] mem_op,
    output logic [4:0] mem_block_x,
    output logic [2:0] mem_block_y,
    output logic [5:0] mem_card,
    output logic       mem_move_dir,
    output logic       opp_turn_done,
    output logic       opp_reset_table,
    output logic       opp_cheat,
    output logic       msg_err,
    output logic       overflow,
    output logic       rx_busy,
    output logic [6:0] opp_card_cnt
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int WORD_W = 22;

    localparam logic [PTR_W:0]   c_depth      = (PTR_W+1)'(FIFO_DEPTH);
    localparam logic [PTR_W-1:0] c_ptr_one    = PTR_W'(1);
    localparam logic [6:0]       c_max_cards  = 7'(MAX_CARDS);
    localparam logic [6:0]       c_init_cards = 7'd14;
    localparam logic [4:0]       c_max_col    = 5'd17;

    localparam logic [3:0] c_table_shift = 4'd2;
    localparam logic [3:0] c_hand_take   = 4'd3;
    localparam logic [3:0] c_hand_down   = 4'd4;
    localparam logic [3:0] c_deck_draw   = 4'd5;
    localparam logic [3:0] c_state_turn  = 4'd6;
    localparam logic [3:0] c_state_rst   = 4'd7;
    localparam logic [3:0] c_state_cheat = 4'd8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_EXEC  = 2'd1,
        ST_SHIFT = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [WORD_W-1:0] fifo_mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [PTR_W:0]    count_q;

    logic [3:0] cmd_type_q;
    logic [4:0] cmd_x_q;
    logic [2:0] cmd_y_q;
    logic [5:0] cmd_card_q;
    logic [2:0] cmd_len_q;
    logic       cmd_dir_q;
    logic [2:0] idx_q, idx_d;

    logic [3:0] hold_op_q;
    logic [4:0] hold_x_q;
    logic [2:0] hold_y_q;
    logic [5:0] hold_card_q;
    logic       hold_dir_q;

    logic       overflow_q;
    logic [6:0] card_cnt_q, card_cnt_d;

    logic              w_empty, w_full, w_pop, w_push, w_drop;
    logic [WORD_W-1:0] w_wr_word, w_rd_word;
    logic [5:0]        w_shift_end;
    logic              w_type_bad, w_x_bad, w_shift_bad, w_legal;
    logic [4:0]        w_col_right, w_col_left, w_shift_col;
    logic [4:0]        w_col;
    logic              w_strobe, w_err, w_turn, w_rst_tbl, w_cheat;

    // ------------------------------------------------------------------
    // Word FIFO; a pop frees a slot in the same cycle, so push-while-full
    // is only lost when the FSM is not also draining.
    // ------------------------------------------------------------------
    assign w_empty   = (count_q == '0);
    assign w_full    = (count_q == c_depth);
    assign w_pop     = (state_q == ST_IDLE) && !w_empty && !interboard_rst;
    assign w_push    = interboard_en && !interboard_rst && (!w_full || w_pop);
    assign w_drop    = interboard_en && !interboard_rst && w_full && !w_pop;
    assign w_wr_word = {interboard_msg_type, interboard_block_x, interboard_block_y,
                        interboard_card, interboard_sel_len, interboard_move_dir};
    assign w_rd_word = fifo_mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (w_push) begin
            fifo_mem_q[wr_ptr_q] <= w_wr_word;
        end
    end

    // ------------------------------------------------------------------
    // Legality and shift column generation
    // ------------------------------------------------------------------
    assign w_shift_end = {1'b0, cmd_x_q} + {3'b000, cmd_len_q};
    assign w_type_bad  = (cmd_type_q > c_state_cheat);
    assign w_x_bad     = (cmd_type_q <= c_deck_draw) && (cmd_x_q > c_max_col);
    assign w_shift_bad = (cmd_type_q == c_table_shift) &&
                         ((cmd_len_q == 3'd0) ||
                          (!cmd_dir_q && (cmd_x_q == 5'd0)) ||
                          (cmd_dir_q && (w_shift_end > 6'd17)));
    assign w_legal     = !(w_type_bad || w_x_bad || w_shift_bad);

    // Right shifts walk from the far end back so no card is overwritten early.
    assign w_col_right = cmd_x_q + {2'b00, cmd_len_q} - 5'd1 - {2'b00, idx_q};
    assign w_col_left  = cmd_x_q + {2'b00, idx_q};
    assign w_shift_col = cmd_dir_q ? w_col_right : w_col_left;

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        w_strobe  = 1'b0;
        w_col     = cmd_x_q;
        w_err     = 1'b0;
        w_turn    = 1'b0;
        w_rst_tbl = 1'b0;
        w_cheat   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!w_empty) begin
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (!w_legal) begin
                    w_err   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    case (cmd_type_q)
                        c_table_shift: begin
                            idx_d   = 3'd0;
                            state_d = ST_SHIFT;
                        end
                        c_state_turn: begin
                            w_turn  = 1'b1;
                            state_d = ST_IDLE;
                        end
                        c_state_rst: begin
                            w_rst_tbl = 1'b1;
                            state_d   = ST_IDLE;
                        end
                        c_state_cheat: begin
                            w_cheat = 1'b1;
                            state_d = ST_IDLE;
                        end
                        default: begin
                            if (!mem_busy) begin
                                w_strobe = 1'b1;
                                state_d  = ST_IDLE;
                            end
                        end
                    endcase
                end
            end
            ST_SHIFT: begin
                if (!mem_busy) begin
                    w_strobe = 1'b1;
                    w_col    = w_shift_col;
                    if (idx_q == (cmd_len_q - 3'd1)) begin
                        state_d = ST_IDLE;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Opponent hand-size tracking
    // ------------------------------------------------------------------
    always_comb begin
        card_cnt_d = card_cnt_q;
        if (mem_en) begin
            case (cmd_type_q)
                c_hand_down, c_deck_draw: begin
                    if (card_cnt_q < c_max_cards) begin
                        card_cnt_d = card_cnt_q + 7'd1;
                    end
                end
                c_hand_take: begin
                    if (card_cnt_q != 7'd0) begin
                        card_cnt_d = card_cnt_q - 7'd1;
                    end
                end
                default: begin
                    card_cnt_d = card_cnt_q;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            idx_q       <= 3'd0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            cmd_type_q  <= 4'd0;
            cmd_x_q     <= 5'd0;
            cmd_y_q     <= 3'd0;
            cmd_card_q  <= 6'd0;
            cmd_len_q   <= 3'd0;
            cmd_dir_q   <= 1'b0;
            hold_op_q   <= 4'd0;
            hold_x_q    <= 5'd0;
            hold_y_q    <= 3'd0;
            hold_card_q <= 6'd0;
            hold_dir_q  <= 1'b0;
            overflow_q  <= 1'b0;
            card_cnt_q  <= c_init_cards;
        end else if (interboard_rst) begin
            state_q     <= ST_IDLE;
            idx_q       <= 3'd0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            cmd_type_q  <= 4'd0;
            cmd_x_q     <= 5'd0;
            cmd_y_q     <= 3'd0;
            cmd_card_q  <= 6'd0;
            cmd_len_q   <= 3'd0;
            cmd_dir_q   <= 1'b0;
            hold_op_q   <= 4'd0;
            hold_x_q    <= 5'd0;
            hold_y_q    <= 3'd0;
            hold_card_q <= 6'd0;
            hold_dir_q  <= 1'b0;
            overflow_q  <= 1'b0;
            card_cnt_q  <= c_init_cards;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            card_cnt_q <= card_cnt_d;
            if (w_push) begin
                wr_ptr_q <= wr_ptr_q + c_ptr_one;
            end
            if (w_pop) begin
                rd_ptr_q <= rd_ptr_q + c_ptr_one;
                {cmd_type_q, cmd_x_q, cmd_y_q, cmd_card_q, cmd_len_q, cmd_dir_q} <= w_rd_word;
            end
            case ({w_push, w_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
            if (w_drop) begin
                overflow_q <= 1'b1;
            end
            if (mem_en) begin
                hold_op_q   <= cmd_type_q;
                hold_x_q    <= w_col;
                hold_y_q    <= cmd_y_q;
                hold_card_q <= cmd_card_q;
                hold_dir_q  <= cmd_dir_q;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs; a pending clear suppresses any strobe in the same cycle.
    // ------------------------------------------------------------------
    assign mem_en          = w_strobe && !interboard_rst;
    assign mem_op          = mem_en ? cmd_type_q : hold_op_q;
    assign mem_block_x     = mem_en ? w_col      : hold_x_q;
    assign mem_block_y     = mem_en ? cmd_y_q    : hold_y_q;
    assign mem_card        = mem_en ? cmd_card_q : hold_card_q;
    assign mem_move_dir    = mem_en ? cmd_dir_q  : hold_dir_q;
    assign opp_turn_done   = w_turn && !interboard_rst;
    assign opp_reset_table = w_rst_tbl && !interboard_rst;
    assign opp_cheat       = w_cheat && !interboard_rst;
    assign msg_err         = w_err && !interboard_rst;
    assign overflow        = overflow_q;
    assign rx_busy         = !w_empty || (state_q != ST_IDLE);
    assign opp_card_cnt    = card_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_interboard_msg_receiver.sv
`default_nettype none
//==============================================================================
// Module   : tb_interboard_msg_receiver
// Brief    : Directed and randomized self-checking bench for the receiver.
// Revision : 1.0 - initial release
//==============================================================================
module tb_interboard_msg_receiver;

    localparam int FIFO_DEPTH = 4;
    localparam int MAX_CARDS  = 106;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       interboard_rst = 1'b0;
    logic       interboard_en = 1'b0;
    logic [3:0] interboard_msg_type = '0;
    logic [4:0] interboard_block_x = '0;
    logic [2:0] interboard_block_y = '0;
    logic [5:0] interboard_card = '0;
    logic [2:0] interboard_sel_len = '0;
    logic       interboard_move_dir = 1'b0;
    logic       mem_busy = 1'b0;
    logic       mem_en;
    logic [3:0] mem_op;
    logic [4:0] mem_block_x;
    logic [2:0] mem_block_y;
    logic [5:0] mem_card;
    logic       mem_move_dir;
    logic       opp_turn_done, opp_reset_table, opp_cheat, msg_err, overflow, rx_busy;
    logic [6:0] opp_card_cnt;

    always #5 clk = ~clk;

    interboard_msg_receiver #(.FIFO_DEPTH(FIFO_DEPTH), .MAX_CARDS(MAX_CARDS)) dut (
        .clk(clk), .rst(rst), .interboard_rst(interboard_rst), .interboard_en(interboard_en),
        .interboard_msg_type(interboard_msg_type), .interboard_block_x(interboard_block_x),
        .interboard_block_y(interboard_block_y), .interboard_card(interboard_card),
        .interboard_sel_len(interboard_sel_len), .interboard_move_dir(interboard_move_dir),
        .mem_busy(mem_busy), .mem_en(mem_en), .mem_op(mem_op), .mem_block_x(mem_block_x),
        .mem_block_y(mem_block_y), .mem_card(mem_card), .mem_move_dir(mem_move_dir),
        .opp_turn_done(opp_turn_done), .opp_reset_table(opp_reset_table), .opp_cheat(opp_cheat),
        .msg_err(msg_err), .overflow(overflow), .rx_busy(rx_busy), .opp_card_cnt(opp_card_cnt)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Monitor: sole writer of the observation log and pulse counters.
    logic [18:0] obs_q[$];
    int n_err = 0, n_turn = 0, n_rtbl = 0, n_cheat = 0, busy_viol = 0;

    always @(negedge clk) begin
        if (mem_en) begin
            obs_q.push_back({mem_op, mem_block_x, mem_block_y, mem_card, mem_move_dir});
            if (mem_busy) busy_viol++;
        end
        if (msg_err)         n_err++;
        if (opp_turn_done)   n_turn++;
        if (opp_reset_table) n_rtbl++;
        if (opp_cheat)       n_cheat++;
    end

    // Reference model state
    logic [18:0] exp_q[$];
    int exp_cnt, exp_err, exp_turn, exp_rtbl, exp_cheat;

    function automatic logic [18:0] pk(input int t, input int x, input int y, input int c, input int d);
        return {4'(t), 5'(x), 3'(y), 6'(c), 1'(d)};
    endfunction

    task automatic model_word(input int t, input int x, input int y, input int c,
                              input int len, input int d);
        bit bad;
        bad = (t > 8) || (t <= 5 && x > 17) ||
              (t == 2 && (len == 0 || (d == 0 && x == 0) || (d == 1 && x + len > 17)));
        if (bad) begin
            exp_err++;
        end else if (t == 2) begin
            for (int i = 0; i < len; i++)
                exp_q.push_back(pk(2, (d == 1) ? (x + len - 1 - i) : (x + i), y, c, d));
        end else if (t <= 5) begin
            exp_q.push_back(pk(t, x, y, c, d));
            if ((t == 4 || t == 5) && exp_cnt < MAX_CARDS) exp_cnt++;
            if (t == 3 && exp_cnt > 0) exp_cnt--;
        end else if (t == 6) exp_turn++;
        else if (t == 7) exp_rtbl++;
        else exp_cheat++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input int t, input int x, input int y, input int c,
                             input int len, input int d);
        interboard_msg_type = 4'(t);
        interboard_block_x  = 5'(x);
        interboard_block_y  = 3'(y);
        interboard_card     = 6'(c);
        interboard_sel_len  = 3'(len);
        interboard_move_dir = 1'(d);
        interboard_en       = 1'b1;
        tick();
        interboard_en       = 1'b0;
    endtask

    task automatic wait_idle(input int max_cycles, input bit rnd_busy);
        bit done;
        done = 1'b0;
        for (int i = 0; i < max_cycles && !done; i++) begin
            if (rnd_busy) mem_busy = ($urandom_range(0, 2) == 0);
            @(negedge clk);
            if (!rx_busy) done = 1'b1;
            tick();
        end
        mem_busy = 1'b0;
        n_tests++;
        if (!done) begin
            n_fail++;
            $display("FAIL wait_idle: rx_busy still %0b after %0d cycles, expected 0", rx_busy, max_cycles);
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        logic [26:0] outs;
        @(negedge clk);
        outs = {mem_en, mem_op, mem_block_x, mem_block_y, mem_card, mem_move_dir,
                opp_turn_done, opp_reset_table, opp_cheat, msg_err, overflow, rx_busy};
        n_tests++;
        if (outs !== '0) begin n_fail++; $display("FAIL reset_outputs: got %h expected 0", outs); end
        n_tests++;
        if (opp_card_cnt !== 7'd14) begin n_fail++; $display("FAIL reset_cnt: got %0d expected 14", opp_card_cnt); end
        tick();
        rst = 1'b1;
        tick();
    endtask

    task automatic test_table_down();
        send_word(1, 3, 2, 17, 0, 0);
        @(negedge clk);
        n_tests++;
        if (mem_en !== 1'b0) begin n_fail++; $display("FAIL td_early: mem_en %b at T+1 expected 0", mem_en); end
        tick();
        @(negedge clk);
        n_tests++;
        if ({mem_en, mem_op, mem_block_x, mem_block_y, mem_card} !== {1'b1, 4'd1, 5'd3, 3'd2, 6'd17}) begin
            n_fail++;
            $display("FAIL td_strobe: en=%b op=%0d x=%0d y=%0d card=%0d expected 1/1/3/2/17",
                     mem_en, mem_op, mem_block_x, mem_block_y, mem_card);
        end
        tick();
        @(negedge clk);
        n_tests++;
        if ({mem_en, rx_busy} !== 2'b00) begin
            n_fail++; $display("FAIL td_after: en=%b rx_busy=%b at T+3 expected 0 0", mem_en, rx_busy);
        end
        tick();
    endtask

    task automatic test_shift_stall();
        int base, bv;
        bit seen;
        base = obs_q.size();
        bv   = busy_viol;
        seen = 1'b0;
        send_word(2, 4, 1, 9, 3, 1);
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (obs_q.size() > base) seen = 1'b1;
            tick();
        end
        mem_busy = 1'b1;
        tick();
        tick();
        mem_busy = 1'b0;
        wait_idle(50, 1'b0);
        n_tests++;
        if (obs_q.size() - base !== 3) begin
            n_fail++; $display("FAIL shift_count: got %0d strobes expected 3", obs_q.size() - base);
        end else begin
            for (int i = 0; i < 3; i++) begin
                n_tests++;
                if (obs_q[base + i] !== pk(2, 6 - i, 1, 9, 1)) begin
                    n_fail++; $display("FAIL shift_cmd%0d: got %h expected %h", i, obs_q[base + i], pk(2, 6 - i, 1, 9, 1));
                end
            end
        end
        n_tests++;
        if (busy_viol !== bv) begin n_fail++; $display("FAIL shift_busy: %0d strobes while busy expected 0", busy_viol - bv); end
    endtask

    task automatic test_illegal();
        int base, e0;
        base = obs_q.size();
        e0   = n_err;
        send_word(2, 0, 0, 5, 2, 0);
        send_word(2, 16, 0, 5, 3, 1);
        send_word(11, 1, 0, 5, 1, 0);
        wait_idle(50, 1'b0);
        n_tests++;
        if (n_err - e0 !== 3) begin n_fail++; $display("FAIL illegal_err: got %0d pulses expected 3", n_err - e0); end
        n_tests++;
        if (obs_q.size() - base !== 0) begin n_fail++; $display("FAIL illegal_mem: got %0d strobes expected 0", obs_q.size() - base); end
    endtask

    task automatic test_overflow();
        int base;
        base = obs_q.size();
        mem_busy = 1'b1;
        for (int i = 0; i < 6; i++) send_word(1, i, 0, 20 + i, 0, 0);
        tick();
        tick();
        n_tests++;
        if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_flag: got %b expected 1", overflow); end
        n_tests++;
        if (obs_q.size() - base !== 0) begin n_fail++; $display("FAIL ovf_stall: got %0d strobes expected 0", obs_q.size() - base); end
        mem_busy = 1'b0;
        wait_idle(100, 1'b0);
        n_tests++;
        if (obs_q.size() - base !== 5) begin
            n_fail++; $display("FAIL ovf_count: got %0d strobes expected 5", obs_q.size() - base);
        end else begin
            for (int i = 0; i < 5; i++) begin
                n_tests++;
                if (obs_q[base + i] !== pk(1, i, 0, 20 + i, 0)) begin
                    n_fail++; $display("FAIL ovf_order%0d: got %h expected %h", i, obs_q[base + i], pk(1, i, 0, 20 + i, 0));
                end
            end
        end
    endtask

    task automatic test_card_count();
        int base, t0;
        do_reset();
        for (int i = 0; i < 15; i++) begin
            send_word(3, 0, 0, 1, 0, 0);
            wait_idle(50, 1'b0);
            n_tests++;
            if (opp_card_cnt !== 7'((13 - i > 0) ? 13 - i : 0)) begin
                n_fail++; $display("FAIL take_cnt%0d: got %0d expected %0d", i, opp_card_cnt, (13 - i > 0) ? 13 - i : 0);
            end
        end
        base = obs_q.size();
        t0   = n_turn;
        send_word(6, 0, 0, 0, 0, 0);
        wait_idle(50, 1'b0);
        n_tests++;
        if (n_turn - t0 !== 1 || obs_q.size() !== base) begin
            n_fail++; $display("FAIL turn: got %0d pulses %0d strobes expected 1 0", n_turn - t0, obs_q.size() - base);
        end
    endtask

    task automatic test_clear();
        int base;
        bit seen;
        do_reset();
        send_word(3, 0, 0, 1, 0, 0);
        wait_idle(50, 1'b0);
        mem_busy = 1'b1;
        for (int i = 0; i < 6; i++) send_word(0, i, 1, i, 0, 0);
        interboard_rst = 1'b1;
        send_word(1, 2, 2, 2, 0, 0);
        interboard_rst = 1'b0;
        base = obs_q.size();
        mem_busy = 1'b0;
        @(negedge clk);
        n_tests++;
        if ({rx_busy, overflow, opp_card_cnt} !== {1'b0, 1'b0, 7'd14}) begin
            n_fail++; $display("FAIL ibrst_state: busy=%b ovf=%b cnt=%0d expected 0 0 14", rx_busy, overflow, opp_card_cnt);
        end
        for (int i = 0; i < 10; i++) tick();
        n_tests++;
        if (obs_q.size() !== base) begin n_fail++; $display("FAIL ibrst_mem: got %0d strobes expected 0", obs_q.size() - base); end

        send_word(3, 0, 0, 1, 0, 0);
        wait_idle(50, 1'b0);
        seen = 1'b0;
        send_word(2, 2, 3, 7, 5, 1);
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (mem_en) seen = 1'b1;
            tick();
        end
        mem_busy = 1'b1;
        tick();
        #2 rst = 1'b0;
        #1;
        n_tests++;
        if ({rx_busy, mem_en, overflow, opp_card_cnt} !== {3'b000, 7'd14}) begin
            n_fail++; $display("FAIL async_rst: busy=%b en=%b ovf=%b cnt=%0d expected 0 0 0 14",
                               rx_busy, mem_en, overflow, opp_card_cnt);
        end
        tick();
        rst = 1'b1;
        mem_busy = 1'b0;
        base = obs_q.size();
        for (int i = 0; i < 10; i++) tick();
        n_tests++;
        if (obs_q.size() !== base) begin n_fail++; $display("FAIL async_mem: got %0d strobes expected 0", obs_q.size() - base); end
    endtask

    task automatic test_random();
        int base, e0, t0, r0, c0, bv, t, x, y, c, len, d;
        do_reset();
        exp_q.delete();
        exp_cnt = 14; exp_err = 0; exp_turn = 0; exp_rtbl = 0; exp_cheat = 0;
        base = obs_q.size();
        e0 = n_err; t0 = n_turn; r0 = n_rtbl; c0 = n_cheat; bv = busy_viol;
        for (int k = 0; k < 60; k++) begin
            t   = (k % 3 == 0) ? 2 : int'($urandom_range(0, 10));
            x   = int'($urandom_range(0, 19));
            y   = int'($urandom_range(0, 7));
            c   = int'($urandom_range(0, 63));
            len = int'($urandom_range(0, 7));
            d   = int'($urandom_range(0, 1));
            model_word(t, x, y, c, len, d);
            send_word(t, x, y, c, len, d);
            wait_idle(200, 1'b1);
        end
        n_tests++;
        if (obs_q.size() - base !== exp_q.size()) begin
            n_fail++; $display("FAIL rnd_count: got %0d commands expected %0d", obs_q.size() - base, exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                n_tests++;
                if (obs_q[base + i] !== exp_q[i]) begin
                    n_fail++; $display("FAIL rnd_cmd%0d: got %h expected %h", i, obs_q[base + i], exp_q[i]);
                end
            end
        end
        n_tests++;
        if ({n_err - e0, n_turn - t0, n_rtbl - r0, n_cheat - c0} !== {exp_err, exp_turn, exp_rtbl, exp_cheat}) begin
            n_fail++; $display("FAIL rnd_events: got err=%0d turn=%0d rst=%0d cheat=%0d expected %0d %0d %0d %0d",
                               n_err - e0, n_turn - t0, n_rtbl - r0, n_cheat - c0, exp_err, exp_turn, exp_rtbl, exp_cheat);
        end
        n_tests++;
        if (opp_card_cnt !== 7'(exp_cnt)) begin n_fail++; $display("FAIL rnd_cnt: got %0d expected %0d", opp_card_cnt, exp_cnt); end
        n_tests++;
        if (busy_viol !== bv) begin n_fail++; $display("FAIL rnd_busy: %0d strobes while busy expected 0", busy_viol - bv); end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_table_down();
        test_shift_stall();
        test_illegal();
        test_overflow();
        test_card_count();
        test_clear();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/interboard_msg_receiver.md
Name: interboard_msg_receiver

Overview:
- Receive end of the board-to-board move protocol: accepts the message words delivered by InterboardCommunication when the opponent board transmits.
- Buffers each word in a small FIFO and decodes it.
- Replays table/hand/deck messages as single-cycle memory write commands, expanding TABLE_SHIFT into one command per shifted card.
- Raises one-pulse turn, reset-table and cheat events toward GameControl; tracks the opponent's hand size.

Parameters:
- FIFO_DEPTH, 4, message words buffered; power of two, minimum 2.
- MAX_CARDS, 106, saturation ceiling of opp_card_cnt.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-low reset
- interboard_rst  input  1  synchronous active-high clear requested by the other board
- interboard_en  input  1  one-pulse; the fields below are valid this cycle
- interboard_msg_type  input  4  0 TABLE_TAKE, 1 TABLE_DOWN, 2 TABLE_SHIFT, 3 HAND_TAKE, 4 HAND_DOWN, 5 DECK_DRAW, 6 STATE_TURN, 7 STATE_RST_TABLE, 8 STATE_CHEAT
- interboard_block_x  input  5  column, 0..17
- interboard_block_y  input  3  row, 0..7
- interboard_card  input  6  card code
- interboard_sel_len  input  3  shift run length
- interboard_move_dir  input  1  0 left, 1 right
- mem_busy  input  1  memory cannot accept a command this cycle
- mem_en  output  1  one-pulse memory command strobe
- mem_op  output  4  the msg_type being applied
- mem_block_x  output  5  target column
- mem_block_y  output  3  target row
- mem_card  output  6  card code
- mem_move_dir  output  1  shift direction
- opp_turn_done  output  1  one-pulse on STATE_TURN
- opp_reset_table  output  1  one-pulse on STATE_RST_TABLE
- opp_cheat  output  1  one-pulse on STATE_CHEAT
- msg_err  output  1  one-pulse when a word is dropped as illegal
- overflow  output  1  sticky; an incoming word was lost because the FIFO was full
- rx_busy  output  1  FIFO non-empty or FSM not in IDLE
- opp_card_cnt  output  7  opponent hand size

Behaviour:
- Reset (rst low, async) and interboard_rst (sync) have identical effect:
  - FIFO is emptied; FSM goes to IDLE.
  - Every output is 0 except opp_card_cnt, which is 14.
  - interboard_rst takes priority over a simultaneous interboard_en; that word is discarded.
- FIFO:
  - Push on interboard_en; the full word is msg_type, x, y, card, sel_len, dir.
  - Push while full and no pop in the same cycle: word dropped, overflow set (cleared only by reset).
  - Simultaneous push and pop while full is legal.
- FSM states: IDLE, EXEC, SHIFT.
- IDLE:
  - If the FIFO is non-empty, pop into command registers and go to EXEC.
  - Latency: interboard_en in cycle T gives its first output in cycle T+2.
- EXEC, legality checks (an illegal word pulses msg_err for 1 cycle, produces no other output, and returns to IDLE):
  - Any msg_type greater than 8.
  - block_x greater than 17 on any table, hand or deck type.
  - TABLE_SHIFT with sel_len 0.
  - TABLE_SHIFT left with x 0.
  - TABLE_SHIFT right with x+sel_len greater than 17, computed at 6 bits.
- EXEC, handling of legal words:
  - Types 0, 1, 3, 4, 5: wait while mem_busy. When mem_busy is low, drive mem_en for 1 cycle with the fields, then return to IDLE.
  - Type 2: go to SHIFT with idx = 0.
  - Types 6, 7, 8: pulse the matching event output for 1 cycle and return to IDLE. These never wait on mem_busy.
- SHIFT:
  - Issues one mem_en (mem_op 2) per cycle in which mem_busy is low, covering sel_len commands.
  - Column order for right shifts: x+sel_len-1 down to x, so that no card is overwritten.
  - Column order for left shifts: x up to x+sel_len-1.
  - Returns to IDLE after the final command; mem_busy stalls the sequence without losing position.
- opp_card_cnt updates in the mem_en cycle:
  - DECK_DRAW and HAND_DOWN add 1; HAND_TAKE subtracts 1.
  - Saturates at 0 and at MAX_CARDS.
  - Not changed by any other type.
- The mem_* fields hold their last value when mem_en is low.

Test Plan:
- Apply reset, then send TABLE_DOWN with x=3, y=2, card=17 in cycle T -> mem_en high in cycle T+2 only, with mem_op=1, x=3, y=2, card=17; rx_busy low at T+3.
- Send TABLE_SHIFT right with x=4, y=1, len=3, and hold mem_busy high for 2 cycles mid-run -> exactly 3 mem_en pulses, at columns 6, 5, 4, with no strobe while busy.
- Send a left shift with x=0, then a right shift with x=16, len=3, then msg_type 11 -> 3 msg_err pulses and zero mem_en.
- Send 6 back-to-back words with mem_busy held high (FIFO_DEPTH=4) -> overflow is set; the first 5 words complete once mem_busy drops (4 buffered plus 1 in the command registers), in order.
- Send 15 HAND_TAKE words -> opp_card_cnt goes 13 … 0, and stays 0 on the 15th. Send STATE_TURN -> single opp_turn_done pulse.
- Fill the FIFO, then assert interboard_rst together with interboard_en -> FIFO is empty, no mem_en follows, opp_card_cnt=14, overflow=0. Repeat the check with rst pulled low asynchronously mid-SHIFT.
